// File: rtl/text_lcd_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : text_lcd_responder_if
//  Description : HD44780-style character-LCD bus. It carries the enable
//                strobe, register select, read/write select and both data
//                directions.
//                  master - the LCD driver side (drives e/rs/rw/data_in)
//                  slave  - the responder side (drives data_out/data_oe)
//  Ports       : none (the interface is a bundle of signals)
//  Revision    : 1.0 - initial release
// ============================================================================
interface text_lcd_responder_if;
    logic       lcd_e;          // enable strobe, asynchronous to the responder clock
    logic       lcd_rs;         // 0 = instruction, 1 = data
    logic       lcd_rw;         // 0 = write, 1 = read
    logic [7:0] lcd_data_in;    // driver -> responder
    logic [7:0] lcd_data_out;   // responder -> driver
    logic       lcd_data_oe;    // responder read data valid / drive enable

    modport master (
        output lcd_e,
        output lcd_rs,
        output lcd_rw,
        output lcd_data_in,
        input  lcd_data_out,
        input  lcd_data_oe
    );

    modport slave (
        input  lcd_e,
        input  lcd_rs,
        input  lcd_rw,
        input  lcd_data_in,
        output lcd_data_out,
        output lcd_data_oe
    );
endinterface
`default_nettype wire

// File: rtl/text_lcd_responder.sv
`default_nettype none
// ============================================================================
//  Module      : text_lcd_responder
//  Description : Receiving end of an HD44780-style character-LCD bus. It
//                decodes bus transactions into a 2x16 DDRAM shadow and
//                answers busy-flag and data reads.
//  Ports       :
//    clk          - system clock
//    rst          - asynchronous, active-low reset
//    bus          - LCD bus (slave modport): e/rs/rw/data_in in,
//                   data_out/data_oe out
//    line1_data   - DDRAM 0x00-0x0F, char at address a in [127-8a -: 8]
//    line2_data   - DDRAM 0x40-0x4F, same packing
//    busy         - internal busy flag
//    ac           - address counter
//    display_on   - D bit of the last display-control command
//    overrun      - one-cycle pulse when a write is dropped because busy=1
//  Revision    : 1.0 - initial release
// ============================================================================
module text_lcd_responder #(
    parameter int BUSY_SHORT = 4,     // busy cycles after ordinary writes
    parameter int BUSY_LONG  = 160    // busy cycles after clear / return-home
) (
    input  wire logic            clk,
    input  wire logic            rst,
    text_lcd_responder_if.slave  bus,
    output logic [127:0]         line1_data,
    output logic [127:0]         line2_data,
    output logic                 busy,
    output logic [6:0]           ac,
    output logic                 display_on,
    output logic                 overrun
);

    localparam int c_BUSY_MAX = (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
    // The counter only ever holds N-1, so clog2(N) bits are enough.
    localparam int c_CNT_W    = (c_BUSY_MAX > 1) ? $clog2(c_BUSY_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_SHORT_LOAD = c_CNT_W'(BUSY_SHORT - 1);
    localparam logic [c_CNT_W-1:0] c_LONG_LOAD  = c_CNT_W'(BUSY_LONG - 1);
    localparam logic [127:0]       c_BLANK      = {16{8'h20}};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic               r_e_s1, r_e_s2, r_e_d;
    logic               r_rs_s1, r_rs_s2;
    logic               r_rw_s1, r_rw_s2;
    logic [7:0]         r_data_s1, r_data_s2;

    logic               r_cap_rs;
    logic               r_cap_rw;
    logic [7:0]         r_cap_data;
    logic               r_act;

    logic [127:0]       r_line1;
    logic [127:0]       r_line2;
    logic [6:0]         r_ac;
    logic               r_id;
    logic               r_display_on;
    logic               r_busy;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_overrun;
    logic [7:0]         r_out;
    logic               r_oe;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               w_in_l1;
    logic               w_in_l2;
    logic [6:0]         w_bit_hi;
    logic [7:0]         w_rd_char;
    logic               w_blocked;

    assign w_in_l1  = (r_ac[6:4] == 3'b000);
    assign w_in_l2  = (r_ac[6:4] == 3'b100);
    // MSB of the character slot addressed by the low nibble of ac.
    assign w_bit_hi = 7'd127 - {r_ac[3:0], 3'b000};

    always_comb begin
        w_rd_char = 8'h20;
        if (w_in_l1) begin
            w_rd_char = r_line1[w_bit_hi -: 8];
        end else if (w_in_l2) begin
            w_rd_char = r_line2[w_bit_hi -: 8];
        end
    end

    // In the last busy cycle the counter is already 0; an action landing
    // there is accepted, so the flag and a new busy period never overlap.
    assign w_blocked = r_busy && (r_cnt != '0);

    // Address counter step. Increment jumps from the end of line 1 (0x27)
    // to line 2 and from the end of line 2 (0x67) back to 0; any address in
    // the gaps also returns to 0. Decrement mirrors the two wrap points.
    function automatic logic [6:0] f_step(input logic [6:0] a, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (a == 7'h27) begin
                nxt = 7'h40;
            end else if (a == 7'h67) begin
                nxt = 7'h00;
            end else if (((a >= 7'h28) && (a <= 7'h3F)) || (a >= 7'h68)) begin
                nxt = 7'h00;
            end else begin
                nxt = a + 7'd1;
            end
        end else begin
            if (a == 7'h00) begin
                nxt = 7'h67;
            end else if (a == 7'h40) begin
                nxt = 7'h27;
            end else begin
                nxt = a - 7'd1;
            end
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Main sequential block
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_e_s1       <= 1'b0;
            r_e_s2       <= 1'b0;
            r_e_d        <= 1'b0;
            r_rs_s1      <= 1'b0;
            r_rs_s2      <= 1'b0;
            r_rw_s1      <= 1'b0;
            r_rw_s2      <= 1'b0;
            r_data_s1    <= 8'h00;
            r_data_s2    <= 8'h00;
            r_cap_rs     <= 1'b0;
            r_cap_rw     <= 1'b0;
            r_cap_data   <= 8'h00;
            r_act        <= 1'b0;
            r_line1      <= c_BLANK;
            r_line2      <= c_BLANK;
            r_ac         <= 7'h00;
            r_id         <= 1'b1;
            r_display_on <= 1'b0;
            r_busy       <= 1'b0;
            r_cnt        <= '0;
            r_overrun    <= 1'b0;
            r_out        <= 8'h00;
            r_oe         <= 1'b0;
        end else begin
            // Two-stage synchronisers for every bus input.
            r_e_s1    <= bus.lcd_e;
            r_e_s2    <= r_e_s1;
            r_e_d     <= r_e_s2;
            r_rs_s1   <= bus.lcd_rs;
            r_rs_s2   <= r_rs_s1;
            r_rw_s1   <= bus.lcd_rw;
            r_rw_s2   <= r_rw_s1;
            r_data_s1 <= bus.lcd_data_in;
            r_data_s2 <= r_data_s1;

            // Keep the last values seen while e was high; the falling edge
            // completes the transaction with them.
            if (r_e_s2) begin
                r_cap_rs   <= r_rs_s2;
                r_cap_rw   <= r_rw_s2;
                r_cap_data <= r_data_s2;
            end

            // Falling edge of synced e -> action in the following cycle.
            r_act <= r_e_d & ~r_e_s2;

            // Read data is presented for as long as synced e is high; the
            // output value is held afterwards.
            r_oe <= r_e_s2 & r_rw_s2;
            if (r_e_s2 && r_rw_s2) begin
                r_out <= r_rs_s2 ? w_rd_char : {r_busy, r_ac};
            end

            // Busy countdown; an accepted action below overrides it.
            if (r_busy) begin
                if (r_cnt == '0) begin
                    r_busy <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
            end

            r_overrun <= 1'b0;

            if (r_act) begin
                if (r_cap_rw && !r_cap_rs) begin
                    // Busy-flag read has no side effects on completion.
                end else if (w_blocked) begin
                    r_overrun <= 1'b1;
                end else if (r_cap_rw) begin
                    // Data read: only the address moves.
                    r_ac <= f_step(r_ac, r_id);
                end else if (r_cap_rs) begin
                    // Data write: store only inside the visible window.
                    if (w_in_l1) begin
                        r_line1[w_bit_hi -: 8] <= r_cap_data;
                    end else if (w_in_l2) begin
                        r_line2[w_bit_hi -: 8] <= r_cap_data;
                    end
                    r_ac   <= f_step(r_ac, r_id);
                    r_busy <= 1'b1;
                    r_cnt  <= c_SHORT_LOAD;
                end else begin
                    // Instruction write, decoded by its highest set bit.
                    casez (r_cap_data)
                        8'b1???????: begin
                            r_ac   <= r_cap_data[6:0];
                            r_busy <= 1'b1;
                            r_cnt  <= c_SHORT_LOAD;
                        end
                        8'b01??????,
                        8'b001?????: begin
                            // CGRAM address and function set have no
                            // visible effect here beyond the busy period.
                            r_busy <= 1'b1;
                            r_cnt  <= c_SHORT_LOAD;
                        end
                        8'b0001????: begin
                            // Cursor shift moves ac; display shift ignored.
                            if (!r_cap_data[3]) begin
                                r_ac <= f_step(r_ac, r_cap_data[2]);
                            end
                            r_busy <= 1'b1;
                            r_cnt  <= c_SHORT_LOAD;
                        end
                        8'b00001???: begin
                            r_display_on <= r_cap_data[2];
                            r_busy       <= 1'b1;
                            r_cnt        <= c_SHORT_LOAD;
                        end
                        8'b000001??: begin
                            r_id   <= r_cap_data[1];
                            r_busy <= 1'b1;
                            r_cnt  <= c_SHORT_LOAD;
                        end
                        8'b0000001?: begin
                            r_ac   <= 7'h00;
                            r_busy <= 1'b1;
                            r_cnt  <= c_LONG_LOAD;
                        end
                        8'b00000001: begin
                            r_line1 <= c_BLANK;
                            r_line2 <= c_BLANK;
                            r_ac    <= 7'h00;
                            r_id    <= 1'b1;
                            r_busy  <= 1'b1;
                            r_cnt   <= c_LONG_LOAD;
                        end
                        default: begin
                            // 0x00: no-op, no busy period.
                        end
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.lcd_data_out = r_out;
    assign bus.lcd_data_oe  = r_oe;
    assign line1_data       = r_line1;
    assign line2_data       = r_line2;
    assign busy             = r_busy;
    assign ac               = r_ac;
    assign display_on       = r_display_on;
    assign overrun          = r_overrun;

endmodule
`default_nettype wire

// File: doc/text_lcd_responder.md
Name: text_lcd_responder

Overview:
Synthesizable HD44780-style character-LCD responder. It is the receiving end of the lcd_e/lcd_rs/lcd_rw/lcd_data bus that the watch's LCD driver produces. It decodes bus transactions into a 2x16 DDRAM shadow, which it exposes as two 128-bit line vectors in the same packing the watch uses. Used as an on-chip loopback/monitor and as the DUT-side model when verifying LCD drivers. It also answers busy-flag and data reads.

Parameters:
BUSY_SHORT, 4, busy cycles after any accepted write other than clear/home
BUSY_LONG, 160, busy cycles after clear (0x01) or return-home (0x02/0x03)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
lcd_e  input  1  bus enable strobe (asynchronous to clk)
lcd_rs  input  1  0 = instruction, 1 = data
lcd_rw  input  1  0 = write, 1 = read
lcd_data_in  input  8  bus data, driver to responder
lcd_data_out  output  8  read data, responder to driver
lcd_data_oe  output  1  read data valid / drive enable
line1_data  output  128  DDRAM 0x00-0x0F; char at address a occupies bits [127-8a -: 8]
line2_data  output  128  DDRAM 0x40-0x4F; same packing
busy  output  1  internal busy flag
ac  output  7  address counter
display_on  output  1  D bit of the last display-control command
overrun  output  1  one-cycle pulse when a write is dropped because busy=1

Behaviour:
- Reset (async, rst=0): all 32 DDRAM chars 0x20. ac=0, I/D=1, display_on=0, busy=0, busy counter=0, lcd_data_oe=0, lcd_data_out=0, overrun=0, sync and edge registers cleared.
- Input capture: lcd_e, lcd_rs, lcd_rw and lcd_data_in go through 2-FF synchronizers. While synced e=1, the rs/rw/data values are registered each cycle. A falling edge of synced e completes the transaction using the last values captured while e was high.
- Action timing: the action executes in the cycle after the falling edge is detected. Outputs update on the following clk edge, so latency is 4 clk from the bus e fall.
- Write while busy=1: dropped. overrun pulses for exactly 1 cycle; no state change.
- Instruction write (rs=0, rw=0), decoded by the highest set bit:
  - 0x00: no-op; no busy period.
  - 0x01 clear: all DDRAM set to 0x20, ac=0, I/D=1, busy for BUSY_LONG.
  - 0x02/0x03 return home: ac=0, busy for BUSY_LONG.
  - 0b000001xx entry mode: I/D=bit1; S bit ignored.
  - 0b00001xxx display control: display_on=bit2; C/B bits ignored.
  - 0b0001xxxx shift: S/C=0 moves ac by one (R/L=bit2: 1 = increment); S/C=1 ignored.
  - 0b001xxxxx function set: ignored.
  - 0b01xxxxxx CGRAM address: ignored.
  - 0b1aaaaaaa: ac=aaaaaaa.
  - Every accepted instruction except 0x00, clear and home starts a BUSY_SHORT period.
- Data write (rs=1, rw=0):
  - If ac is in 0x00-0x0F or 0x40-0x4F, the char is stored; otherwise it is discarded.
  - ac then steps by one per I/D. Busy for BUSY_SHORT.
- ac stepping (increment):
  - 0x27 -> 0x40
  - 0x67 -> 0x00
  - any value in 0x28-0x3F or 0x68-0x7F -> 0x00
- ac stepping (decrement):
  - 0x00 -> 0x67
  - 0x40 -> 0x27
- Busy-flag read (rs=0, rw=1):
  - While synced e=1: lcd_data_oe=1 and lcd_data_out={busy, ac}.
  - No state change; served even when busy.
- Data read (rs=1, rw=1):
  - While synced e=1: lcd_data_oe=1 and lcd_data_out = char at ac, or 0x20 if ac is outside the visible window.
  - On e fall: ac steps per I/D. Ignored with overrun if busy.
- lcd_data_oe behaviour:
  - Returns to 0 the cycle after synced e falls.
  - lcd_data_out holds its last value.
- Busy counter: loads N-1 on the action cycle, so busy stays high for exactly N cycles. A new accepted action cannot occur while busy.
- Mid-transaction events:
  - Reset: aborts the transaction and busy period; reset values apply immediately.
  - e pulse shorter than 1 synced cycle: may be missed; no partial effects allowed.
- Simultaneous busy expiry and e fall: busy is evaluated at the action cycle. If the counter reached 0 in that cycle, the write is accepted.

Test Plan:
1. Reset -> line1_data and line2_data = {16{8'h20}}, ac=0, busy=0, lcd_data_oe=0.
2. Write 0x80, then data 0x41, 0x42 -> line1_data[127:112]=16'h4142, ac=0x02; busy high BUSY_SHORT cycles after each write.
3. Write 0xC0, then 17 data writes of 0x30..0x40 -> line2_data = 0x30..0x3F in order, ac=0x51, 17th char discarded, line1 unchanged.
4. Write 0x01 -> busy for 160 cycles. Busy read during that period returns 8'b1xxxxxxx; after it, 0x00. All chars are 0x20. A data write issued 10 cycles after the clear -> overrun pulse, DDRAM unchanged.
5. Entry mode 0x04, set address 0x80, write 0x5A -> char 0 = 0x5A, ac=0x67. Then set 0x8F, entry 0x06, write twice -> ac 0x8F char stored, ac goes 0x10 then 0x11.
6. Set address 0x85, write 0x31, set 0x85, data read -> lcd_data_out=0x31 with oe=1 while e high, ac=0x06 after. Asserting rst during a BUSY_LONG period -> busy=0 and all chars 0x20 immediately.
